// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: ALUControl opcodes, flag bit positions and the
// arbiter FSM state type shared by alu_arbiter and its users.
package alu_ctrl_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_SLT = 4'b0101;
    localparam logic [3:0] OP_SLL = 4'b0110;
    localparam logic [3:0] OP_SRL = 4'b0111;
    localparam logic [3:0] OP_SRA = 4'b1000;
    localparam logic [3:0] OP_MUL = 4'b1001;
    localparam logic [3:0] OP_DIV = 4'b1010;

    localparam logic [3:0] OP_MAX_LEGAL = OP_DIV;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_e;

    function automatic logic op_legal(input logic [3:0] op);
        return op <= OP_MAX_LEGAL;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-input round-robin grant.
// ptr names the preferred requester; a lone valid always wins.
module rr_arbiter2 (
    input  logic [1:0] valid,
    input  logic       ptr,
    output logic [1:0] grant,
    output logic       gnt_id
);

    // pick the preferred requester, fall back to the other one
    always_comb begin
        gnt_id = ptr;
        if (!valid[ptr]) begin
            gnt_id = ~ptr;
        end
        grant         = '0;
        grant[gnt_id] = valid[gnt_id];
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external ALU between two requesters.
// Define ALU_ARBITER_FLAGS_EN to build the per-requester flag registers.
module alu_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int N        = 32,
    parameter int DIV_WAIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [1:0][N-1:0]   req_a,
    input  logic [1:0][N-1:0]   req_b,
    input  logic [1:0][3:0]     req_op,
    input  logic [1:0]          req_setf,
    output logic [N-1:0]        alu_a,
    output logic [N-1:0]        alu_b,
    output logic [3:0]          alu_ctrl,
    input  logic [N-1:0]        alu_result,
    input  logic [3:0]          alu_flags,
    output logic [1:0]          rsp_valid,
    input  logic [1:0]          rsp_ready,
    output logic [N-1:0]        rsp_result,
    output logic [3:0]          rsp_flags,
    output logic                rsp_err,
    output logic [1:0][3:0]     flags_q
);

    localparam logic [3:0] DIV_CNT = 4'(DIV_WAIT);

    state_e         state_d, state_q;
    logic           ptr_d, ptr_q;
    logic [3:0]     cnt_d, cnt_q;
    logic           id_d, id_q;
    logic [N-1:0]   alu_a_d, alu_a_q;
    logic [N-1:0]   alu_b_d, alu_b_q;
    logic [3:0]     alu_ctrl_d, alu_ctrl_q;
    logic [N-1:0]   rsp_result_d, rsp_result_q;
    logic [3:0]     rsp_flags_d, rsp_flags_q;
    logic           rsp_err_d, rsp_err_q;

    logic [1:0]     gnt;
    logic           gnt_id;
    logic           rsp_fire;

    rr_arbiter2 u_arb (
        .valid  (req_valid),
        .ptr    (ptr_q),
        .grant  (gnt),
        .gnt_id (gnt_id)
    );

    assign rsp_fire = (state_q == RESP) && rsp_ready[id_q];

    // grant, execute and respond; illegal opcodes bypass the ALU
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        id_d         = id_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_ctrl_d   = alu_ctrl_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        rsp_err_d    = rsp_err_q;
        req_ready    = '0;
        unique case (state_q)
            IDLE: begin
                if (!rst && (|req_valid)) begin
                    req_ready = gnt;
                    id_d      = gnt_id;
                    if (op_legal(req_op[gnt_id])) begin
                        alu_a_d    = req_a[gnt_id];
                        alu_b_d    = req_b[gnt_id];
                        alu_ctrl_d = req_op[gnt_id];
                        cnt_d      = (req_op[gnt_id] == OP_DIV)
                                   ? DIV_CNT : 4'd1;
                        state_d    = EXEC;
                    end else begin
                        rsp_result_d = '0;
                        rsp_flags_d  = '0;
                        rsp_err_d    = 1'b1;
                        state_d      = RESP;
                    end
                end
            end
            EXEC: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    rsp_result_d = alu_result;
                    rsp_flags_d  = alu_flags;
                    rsp_err_d    = 1'b0;
                    state_d      = RESP;
                end
            end
            RESP: begin
                if (rsp_fire) begin
                    state_d = IDLE;
                    ptr_d   = ~id_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ptr_q        <= 1'b0;
            cnt_q        <= '0;
            id_q         <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_ctrl_q   <= '0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            id_q         <= id_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_ctrl_q   <= alu_ctrl_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    // address the response to the latched requester
    always_comb begin
        rsp_valid = '0;
        if (state_q == RESP) begin
            rsp_valid[id_q] = 1'b1;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_ctrl   = alu_ctrl_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;
    assign rsp_err    = rsp_err_q;

`ifdef ALU_ARBITER_FLAGS_EN
    logic            accept;
    logic            setf_d, setf_q;
    logic [1:0][3:0] flg_d, flg_q;

    assign accept = (state_q == IDLE) && (|req_ready);

    // latch setf at grant, commit flags on a good handshake
    always_comb begin
        setf_d = setf_q;
        flg_d  = flg_q;
        if (accept) begin
            setf_d = req_setf[gnt_id];
        end
        if (rsp_fire && setf_q && !rsp_err_q) begin
            flg_d[id_q] = rsp_flags_q;
        end
    end

    // flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            setf_q <= 1'b0;
            flg_q  <= '0;
        end else begin
            setf_q <= setf_d;
            flg_q  <= flg_d;
        end
    end

    assign flags_q = flg_q;
`else
    logic unused_setf;
    assign unused_setf = ^req_setf;
    assign flags_q     = '0;
`endif

endmodule
